// File: rtl/ddr3_req_frontend.sv
// Request FIFO and open-row tracker sitting in front of the DDR3 command FSM.
// Each queued request is pre-split into bank/row/column; hit/miss flags compare the head with the row table.
module ddr3_req_frontend #(
    parameter int DEPTH      = 4,
    parameter int ADDR_MCTRL = 32,
    parameter int BA_BITS    = 3,
    parameter int ROW_BITS   = 13,
    parameter int COL_BITS   = 13,
    parameter int DQ_BITS    = 8,
    parameter int BURST_L    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cpu_valid,
    output logic                         cpu_ready,
    input  logic                         cpu_wr,
    input  logic [ADDR_MCTRL-1:0]        cpu_addr,
    input  logic [DQ_BITS*BURST_L-1:0]   cpu_wdata,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic                         req_wr,
    output logic [BA_BITS-1:0]           req_bank,
    output logic [ROW_BITS-1:0]          req_row,
    output logic [COL_BITS-1:0]          req_col,
    output logic [DQ_BITS*BURST_L-1:0]   req_wdata,
    output logic                         req_page_hit,
    output logic                         req_page_miss,
    input  logic                         act_i,
    input  logic [BA_BITS-1:0]           act_bank,
    input  logic [ROW_BITS-1:0]          act_row,
    input  logic                         pre_i,
    input  logic [BA_BITS-1:0]           pre_bank,
    input  logic                         pre_all_i,
    output logic [$clog2(DEPTH):0]       fifo_count
);

    localparam int WD        = DQ_BITS * BURST_L;
    localparam int PW        = $clog2(DEPTH);
    localparam int CW        = PW + 1;
    localparam int NB        = 1 << BA_BITS;
    localparam int ROW_LO    = COL_BITS + BA_BITS;
    localparam int ADDR_USED = ROW_LO + ROW_BITS;
    localparam logic [COL_BITS-1:0] COL_MASK = ~COL_BITS'(BURST_L - 1);

    logic                mem_wr_q   [DEPTH];
    logic [BA_BITS-1:0]  mem_bank_q [DEPTH];
    logic [ROW_BITS-1:0] mem_row_q  [DEPTH];
    logic [COL_BITS-1:0] mem_col_q  [DEPTH];
    logic [WD-1:0]       mem_data_q [DEPTH];

    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [NB-1:0]       open_q, open_d;
    logic [ROW_BITS-1:0] row_tbl_q [NB];

    logic push, pop;
    logic [BA_BITS-1:0]  push_bank;
    logic [ROW_BITS-1:0] push_row;
    logic [COL_BITS-1:0] push_col;

    if (ADDR_MCTRL > ADDR_USED) begin : g_unused_addr
        logic unused_addr_hi;
        assign unused_addr_hi = ^cpu_addr[ADDR_MCTRL-1:ADDR_USED];
    end

    assign cpu_ready  = (count_q != CW'(DEPTH));
    assign req_valid  = (count_q != '0);
    assign fifo_count = count_q;
    assign push       = cpu_valid && cpu_ready;
    assign pop        = req_valid && req_ready;

    // Column is burst aligned by dropping the beat-select bits.
    assign push_col  = cpu_addr[COL_BITS-1:0] & COL_MASK;
    assign push_bank = cpu_addr[ROW_LO-1:COL_BITS];
    assign push_row  = cpu_addr[ADDR_USED-1:ROW_LO];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
    end

    // ACT is applied last so a same-cycle PRE/PRE-all plus ACT leaves the bank open.
    always_comb begin
        open_d = open_q;
        if (pre_all_i) open_d = '0;
        if (pre_i)     open_d[pre_bank] = 1'b0;
        if (act_i)     open_d[act_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            open_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            open_q   <= open_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_wr_q[wr_ptr_q]   <= cpu_wr;
            mem_bank_q[wr_ptr_q] <= push_bank;
            mem_row_q[wr_ptr_q]  <= push_row;
            mem_col_q[wr_ptr_q]  <= push_col;
            mem_data_q[wr_ptr_q] <= cpu_wdata;
        end
        if (act_i) row_tbl_q[act_bank] <= act_row;
    end

    assign req_wr    = mem_wr_q[rd_ptr_q];
    assign req_bank  = mem_bank_q[rd_ptr_q];
    assign req_row   = mem_row_q[rd_ptr_q];
    assign req_col   = mem_col_q[rd_ptr_q];
    assign req_wdata = mem_data_q[rd_ptr_q];

    assign req_page_hit  = req_valid && open_q[req_bank] && (row_tbl_q[req_bank] == req_row);
    assign req_page_miss = req_valid && open_q[req_bank] && (row_tbl_q[req_bank] != req_row);

endmodule

// File: tb/tb_ddr3_req_frontend.sv
// Scoreboard bench for ddr3_req_frontend: accepted pushes queue expected entries, a negedge monitor checks each pop.
module tb_ddr3_req_frontend;

    logic        clk = 1'b0;
    logic        rst_n, cpu_valid, cpu_ready, cpu_wr;
    logic [31:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic        req_valid, req_ready, req_wr;
    logic [2:0]  req_bank;
    logic [12:0] req_row, req_col;
    logic [63:0] req_wdata;
    logic        req_page_hit, req_page_miss;
    logic        act_i, pre_i, pre_all_i;
    logic [2:0]  act_bank, pre_bank;
    logic [12:0] act_row;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    ddr3_req_frontend dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
        .req_wdata(req_wdata), .req_page_hit(req_page_hit), .req_page_miss(req_page_miss),
        .act_i(act_i), .act_bank(act_bank), .act_row(act_row),
        .pre_i(pre_i), .pre_bank(pre_bank), .pre_all_i(pre_all_i),
        .fifo_count(fifo_count)
    );

    typedef struct packed {
        logic        wr;
        logic [2:0]  bank;
        logic [12:0] row;
        logic [12:0] col;
        logic [63:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        vec_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Reference split written arithmetically: 8 KiB column space, 8 banks, 8K rows.
    function automatic exp_t mk(input logic wr, input logic [31:0] addr, input logic [63:0] wd);
        exp_t e;
        e.wr    = wr;
        e.col   = 13'(((addr % 32'd8192) / 32'd8) * 32'd8);
        e.bank  = 3'((addr / 32'd8192) % 32'd8);
        e.row   = 13'((addr / 32'd65536) % 32'd8192);
        e.wdata = wd;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic wr, input logic [31:0] addr, input logic [63:0] wd);
        bit acc = 0;
        cpu_valid = 1'b1;
        cpu_wr    = wr;
        cpu_addr  = addr;
        cpu_wdata = wd;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (cpu_ready) begin
                exp_q.push_back(mk(wr, addr, wd));
                acc = 1;
            end
            tick();
            if (acc) break;
        end
        cpu_valid = 1'b0;
        if (!acc) chk("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        req_ready = 1'b1;
        while (req_valid && n < 40) begin
            tick();
            n++;
        end
        req_ready = 1'b0;
        chk("drain_empty", {63'd0, req_valid}, 64'd0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && req_valid && req_ready) begin
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL pop_unexpected: got a pop, expected an empty scoreboard");
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_wr",   {63'd0, req_wr},   {63'd0, e.wr});
                    chk("pop_bank", {61'd0, req_bank}, {61'd0, e.bank});
                    chk("pop_row",  {51'd0, req_row},  {51'd0, e.row});
                    chk("pop_col",  {51'd0, req_col},  {51'd0, e.col});
                    if (e.wr) chk("pop_wdata", req_wdata, e.wdata);
                end
            end
        end
    end

    initial begin
        rst_n = 0; cpu_valid = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        req_ready = 0; act_i = 0; act_bank = '0; act_row = '0;
        pre_i = 0; pre_bank = '0; pre_all_i = 0;
        repeat (2) tick();
        rst_n = 1;
        @(negedge clk);
        chk("rst_cpu_ready", {63'd0, cpu_ready}, 64'd1);
        chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
        chk("rst_count",     {61'd0, fifo_count}, 64'd0);
        chk("rst_hit",       {63'd0, req_page_hit}, 64'd0);
        chk("rst_miss",      {63'd0, req_page_miss}, 64'd0);
        tick();

        // Single read; head fields checked against hand-split values.
        push_req(1'b0, 32'h0123_4567, 64'h0);
        @(negedge clk);
        chk("rd_valid", {63'd0, req_valid}, 64'd1);
        chk("rd_wr",    {63'd0, req_wr}, 64'd0);
        chk("rd_col",   {51'd0, req_col}, 64'h0560);
        chk("rd_bank",  {61'd0, req_bank}, 64'd2);
        chk("rd_row",   {51'd0, req_row}, 64'h0123);
        chk("rd_hit",   {63'd0, req_page_hit}, 64'd0);
        chk("rd_miss",  {63'd0, req_page_miss}, 64'd0);
        chk("rd_count", {61'd0, fifo_count}, 64'd1);
        tick();

        act_i = 1; act_bank = 3'd2; act_row = 13'h0123;
        tick();
        act_i = 0;
        @(negedge clk);
        chk("act_hit",  {63'd0, req_page_hit}, 64'd1);
        chk("act_miss", {63'd0, req_page_miss}, 64'd0);
        tick();
        pre_i = 1; pre_bank = 3'd2;
        tick();
        pre_i = 0;
        @(negedge clk);
        chk("pre_hit",  {63'd0, req_page_hit}, 64'd0);
        chk("pre_miss", {63'd0, req_page_miss}, 64'd0);
        tick();

        act_i = 1; act_bank = 3'd2; act_row = 13'h0011;
        tick();
        act_i = 0;
        @(negedge clk);
        chk("other_row_miss", {63'd0, req_page_miss}, 64'd1);
        chk("other_row_hit",  {63'd0, req_page_hit}, 64'd0);
        tick();
        pre_all_i = 1; act_i = 1; act_bank = 3'd2; act_row = 13'h0123;
        tick();
        pre_all_i = 0; act_i = 0;
        @(negedge clk);
        chk("preall_act_hit",  {63'd0, req_page_hit}, 64'd1);
        chk("preall_act_miss", {63'd0, req_page_miss}, 64'd0);
        tick();

        drain();
        @(negedge clk);
        chk("empty_hit", {63'd0, req_page_hit}, 64'd0);
        tick();

        // Fill with writes, then a push refused while a pop happens.
        push_req(1'b1, 32'h0000_0000, 64'h1111_1111_1111_1111);
        push_req(1'b1, 32'h0001_2008, 64'h2222_2222_2222_2222);
        push_req(1'b1, 32'h00AB_E3F0, 64'h3333_3333_3333_3333);
        push_req(1'b1, 32'hFFFF_FFFF, 64'h4444_4444_4444_4444);
        @(negedge clk);
        chk("full_ready", {63'd0, cpu_ready}, 64'd0);
        chk("full_count", {61'd0, fifo_count}, 64'd4);
        tick();
        cpu_valid = 1; cpu_wr = 1; cpu_addr = 32'h0000_4000; cpu_wdata = 64'h5555_5555_5555_5555;
        req_ready = 1;
        @(negedge clk);
        chk("full_refuse_ready", {63'd0, cpu_ready}, 64'd0);
        tick();
        cpu_valid = 0; req_ready = 0;
        @(negedge clk);
        chk("refused_count", {61'd0, fifo_count}, 64'd3);
        tick();
        drain();

        // Steady push+pop at occupancy 2 across pointer wrap.
        push_req(1'b1, 32'h0002_0010, 64'hA000_0000_0000_0001);
        push_req(1'b0, 32'h0004_6020, 64'hA000_0000_0000_0002);
        for (int i = 0; i < 10; i++) begin
            cpu_valid = 1;
            cpu_wr    = i[0];
            cpu_addr  = 32'h0010_0000 * i + 32'h0000_2000 * (i % 8) + 32'd8 * i;
            cpu_wdata = 64'hB000_0000_0000_0000 + 64'(i);
            req_ready = 1;
            @(negedge clk);
            chk("stream_count", {61'd0, fifo_count}, 64'd2);
            chk("stream_ready", {63'd0, cpu_ready}, 64'd1);
            if (cpu_ready) exp_q.push_back(mk(cpu_wr, cpu_addr, cpu_wdata));
            tick();
        end
        cpu_valid = 0;
        req_ready = 0;
        drain();

        // Mid-operation reset discards entries and closes banks.
        push_req(1'b0, 32'h00AA_A018, 64'h0);
        push_req(1'b1, 32'h0000_0100, 64'hC0C0_C0C0_C0C0_C0C0);
        push_req(1'b0, 32'h0000_0200, 64'h0);
        act_i = 1; act_bank = 3'd5; act_row = 13'h00AA;
        tick();
        act_i = 0;
        @(negedge clk);
        chk("b5_hit_before_rst", {63'd0, req_page_hit}, 64'd1);
        chk("count_before_rst",  {61'd0, fifo_count}, 64'd3);
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_valid", {63'd0, req_valid}, 64'd0);
        chk("mid_rst_count", {61'd0, fifo_count}, 64'd0);
        chk("mid_rst_ready", {63'd0, cpu_ready}, 64'd1);
        chk("mid_rst_hit",   {63'd0, req_page_hit}, 64'd0);
        tick();
        push_req(1'b0, 32'h00AA_A018, 64'h0);
        @(negedge clk);
        chk("b5_valid_after_rst", {63'd0, req_valid}, 64'd1);
        chk("b5_hit_after_rst",   {63'd0, req_page_hit}, 64'd0);
        chk("b5_miss_after_rst",  {63'd0, req_page_miss}, 64'd0);
        tick();
        drain();
        repeat (2) tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
